hit_judge: RTL and testbench
============================

# hit_judge

Scoring judge for the dance game. Each cycle it compares the player's debounced arrow presses with the bottom two rows of the four scrolling arrow lanes. It grades each lane as PERFECT, GOOD, MISS or STRAY and tracks the current combo and the best combo. Resulting points are converted into single-cycle increment/decrement pulses that feed the digit-chain score counter. It sits between the lane shift registers and input conditioners (upstream) and the score counter (downstream), on the same divided game clock.

## Interface
- COMBO_BONUS, 10: combo value at or above which awarded points double.
- PEND_MAX, 63: saturation limit of each pending-pulse counter (6-bit).
- clk  input  1  divided game clock; lanes shift once per cycle.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  judging enabled; the drain still runs when low.
- row_pre  input  4  second-to-last row of lanes {left, up, down, right} = [3:0].
- row_last  input  4  bottom row of lanes, same ordering.
- press  input  4  one-cycle press pulses from the input conditioners, same ordering.
- inc  output  1  one-cycle pulse: add one to the score.
- dec  output  1  one-cycle pulse: subtract one from the score.
- judge  output  12  per-lane 3-bit judge code; lane i at [3i+2:3i]; registered.
- combo  output  8  current combo, saturating at 255.
- max_combo  output  8  highest combo since reset.

## Operation
- Reset value of every output and all state is 0: inc, dec, judge (all lanes JUDGE_NONE), combo, max_combo, both pending counters, and all consumed flags.
- Per-lane judgement applies only when enable=1, in priority order:
  1. PERFECT: press[i] & row_last[i] & ~consumed[i].
  2. GOOD: press[i] & row_pre[i], when not PERFECT. Sets consumed[i].
  3. STRAY: press[i] with neither condition above.
  4. MISS: ~press[i] & row_last[i] & ~consumed[i].
  5. Otherwise JUDGE_NONE.
- The consumed flag clears on every cycle in which it was set on entry. This covers the early-hit arrow reaching row_last, so that arrow is never judged MISS.
- Each cycle with row_last[i]=1 is one arrow. Back-to-back arrows are judged independently.
- Points:
  - PERFECT = 2, GOOD = 1.
  - If combo ≥ COMBO_BONUS at the start of the cycle, each hit's points double.
  - All lanes' points are summed (maximum 16 per cycle).
  - Each MISS or STRAY adds 1 to pend_dec.
- Combo:
  - If any lane is MISS or STRAY this cycle, combo becomes 0. This takes priority over any hits in the same cycle.
  - Otherwise combo += number of PERFECT/GOOD lanes, saturating at 255.
  - max_combo updates to the new combo whenever the new combo exceeds it.
- Drain, decided from the pend_inc/pend_dec values at the start of the cycle:
  - Both nonzero: decrement both; no pulse is emitted.
  - Only pend_inc nonzero: decrement it; inc is registered high for the next cycle.
  - Only pend_dec nonzero: decrement it; dec is registered high for the next cycle.
  - Both zero: nothing.
  - inc and dec are never high together.
- Pending update: new value = old − drain + added, saturating at PEND_MAX.
- When enable=0: judge is forced to JUDGE_NONE, consumed flags and combo hold, and the drain continues.
- Asserting reset mid-operation clears everything, including pending pulses, which are lost.

## Timing
- judge, combo and max_combo reflect the inputs of cycle t during cycle t+1.
- A press at cycle t raises pending at t+1. The first inc/dec pulse appears in cycle t+2.
- An award of N points yields N inc pulses on consecutive cycles, provided no cancellation occurs.
- There are no combinational paths from inputs to outputs.

## Structure
- The shared package ddr_pkg holds:
  - the judge codes (3-bit): JUDGE_NONE=0, PERFECT=1, GOOD=2, MISS=3, STRAY=4;
  - the point constants PTS_PERFECT=2 and PTS_GOOD=1.
- Sub-module lane_judge, instantiated 4 times:
  - owns its lane's consumed flag and registered judge code;
  - emits hit points, a hit flag and a fault flag.
- The top level (hit_judge) holds the point adder, the combo/max logic, and the pending counters with the drain logic.

## Test plan
- Reset mid-run: with pend_inc=5 and combo=7, pulse reset low → all outputs 0 immediately; no inc pulses after release.
- Perfect hit: row_last=4'b0001 with press=4'b0001 at t, combo 0 → judge[2:0]=PERFECT at t+1; inc high at t+2 and t+3; combo=1.
- Early hit:
  - row_pre=4'b0010 and press=4'b0010 at t → GOOD.
  - row_last=4'b0010 with no press at t+1 → JUDGE_NONE (no MISS).
  - Exactly one inc pulse.
- Miss breaks the combo: combo=5, row_last=4'b0100 with no press → MISS; combo=0; one dec pulse; max_combo stays 5.
- Bonus with cancellation:
  - combo=10, PERFECT on lane 0 and STRAY on lane 1 in the same cycle → pend_inc=4, pend_dec=1.
  - The first drain cycle cancels one of each; then exactly 3 inc pulses follow and no dec pulse.
- Saturation: PERFECT on all four lanes for 8 cycles at combo ≥ 10 → pend_inc holds at 63 and does not wrap; inc then stays high for 63 consecutive cycles.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the dance-game scoring path: judge codes, point
// values and the limits used by the judge and its pending-pulse counters.
package ddr_pkg;

  typedef enum logic [2:0] {
    JUDGE_NONE = 3'd0,
    PERFECT    = 3'd1,
    GOOD       = 3'd2,
    MISS       = 3'd3,
    STRAY      = 3'd4
  } judge_e;

  localparam logic [2:0] PTS_PERFECT = 3'd2;
  localparam logic [2:0] PTS_GOOD    = 3'd1;
  localparam int         COMBO_BONUS = 10;
  localparam int         PEND_MAX    = 63;
  localparam int         N_LANES     = 4;

  // Clamp an unsigned sum to the pending-counter range.
  function automatic logic [5:0] sat_pend(input logic [7:0] v);
    return (v > 8'(PEND_MAX)) ? 6'(PEND_MAX) : v[5:0];
  endfunction

endpackage

// File: rtl/lane_judge.sv
// Grades one arrow lane per cycle and remembers an early (GOOD) hit so the
// same arrow is not graded MISS when it reaches the bottom row.
module lane_judge
  import ddr_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       bonus,
  input  logic       pre,
  input  logic       last,
  input  logic       press,
  output logic [2:0] points,
  output logic       hit,
  output logic       fault,
  output judge_e     judge
);

  logic       consumed;
  judge_e     code;
  logic [2:0] base;

  always_comb begin
    code = JUDGE_NONE;
    if (enable) begin
      if (press && last && !consumed)  code = PERFECT;
      else if (press && pre)           code = GOOD;
      else if (press)                  code = STRAY;
      else if (last && !consumed)      code = MISS;
    end
  end

  always_comb begin
    base = 3'd0;
    if (code == PERFECT)   base = PTS_PERFECT;
    else if (code == GOOD) base = PTS_GOOD;
    points = bonus ? (base << 1) : base;
    hit    = (code == PERFECT) || (code == GOOD);
    fault  = (code == MISS) || (code == STRAY);
  end

  // A GOOD re-arms the flag; any other enabled cycle clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      consumed <= 1'b0;
      judge    <= JUDGE_NONE;
    end else begin
      if (enable) consumed <= (code == GOOD);
      judge <= code;
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Scoring judge: grades four lanes, tracks combo/max combo and turns awarded
// or lost points into single-cycle inc/dec pulses for the score counter.
module hit_judge
  import ddr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  row_pre,
  input  logic [3:0]  row_last,
  input  logic [3:0]  press,
  output logic        inc,
  output logic        dec,
  output logic [11:0] judge,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo
);

  logic [2:0] lane_pts   [N_LANES];
  logic [3:0] lane_hit;
  logic [3:0] lane_fault;
  judge_e     lane_code  [N_LANES];
  logic       bonus;

  assign bonus = (combo >= 8'(COMBO_BONUS));

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    lane_judge u_lane (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bonus  (bonus),
      .pre    (row_pre[i]),
      .last   (row_last[i]),
      .press  (press[i]),
      .points (lane_pts[i]),
      .hit    (lane_hit[i]),
      .fault  (lane_fault[i]),
      .judge  (lane_code[i])
    );
    assign judge[3*i +: 3] = lane_code[i];
  end

  logic [4:0] pts_sum;
  logic [2:0] hit_cnt;
  logic [2:0] fault_cnt;

  always_comb begin
    pts_sum   = 5'd0;
    hit_cnt   = 3'd0;
    fault_cnt = 3'd0;
    for (int i = 0; i < N_LANES; i++) begin
      pts_sum   = pts_sum + 5'(lane_pts[i]);
      hit_cnt   = hit_cnt + 3'(lane_hit[i]);
      fault_cnt = fault_cnt + 3'(lane_fault[i]);
    end
  end

  logic [8:0] combo_sum;
  logic [7:0] combo_next;

  always_comb begin
    combo_sum  = {1'b0, combo} + 9'(hit_cnt);
    combo_next = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    if (|lane_fault) combo_next = 8'd0;
  end

  logic [5:0] pend_inc;
  logic [5:0] pend_dec;
  logic       drain_inc;
  logic       drain_dec;

  // Each nonzero counter drains by one; a pulse only leaves when the other
  // side is empty, so simultaneous gains and losses cancel silently.
  assign drain_inc = (pend_inc != 6'd0);
  assign drain_dec = (pend_dec != 6'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_inc  <= 6'd0;
      pend_dec  <= 6'd0;
      inc       <= 1'b0;
      dec       <= 1'b0;
      combo     <= 8'd0;
      max_combo <= 8'd0;
    end else begin
      pend_inc  <= sat_pend(8'(pend_inc) - 8'(drain_inc) + 8'(pts_sum));
      pend_dec  <= sat_pend(8'(pend_dec) - 8'(drain_dec) + 8'(fault_cnt));
      inc       <= drain_inc && !drain_dec;
      dec       <= drain_dec && !drain_inc;
      combo     <= combo_next;
      if (combo_next > max_combo) max_combo <= combo_next;
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural scoring model.
module tb_hit_judge;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  row_pre;
  logic [3:0]  row_last;
  logic [3:0]  press;
  logic        inc;
  logic        dec;
  logic [11:0] judge;
  logic [7:0]  combo;
  logic [7:0]  max_combo;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  hit_judge dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .row_pre   (row_pre),
    .row_last  (row_last),
    .press     (press),
    .inc       (inc),
    .dec       (dec),
    .judge     (judge),
    .combo     (combo),
    .max_combo (max_combo)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Codes: 0 none, 1 perfect, 2 good, 3 miss, 4 stray.
  int m_cons  [4];
  int m_code  [4];
  int m_combo, m_max, m_pinc, m_pdec;
  bit m_inc, m_dec;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    int pts, hits, faults, mult;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_cons[i] = 0;
        m_code[i] = 0;
      end
      m_combo = 0; m_max = 0; m_pinc = 0; m_pdec = 0;
      m_inc = 0; m_dec = 0;
    end else begin
      pts = 0; hits = 0; faults = 0;
      mult = (m_combo >= 10) ? 2 : 1;
      for (int i = 0; i < 4; i++) begin
        m_code[i] = 0;
        if (enable) begin
          if (press[i] && row_last[i] && m_cons[i] == 0) begin
            m_code[i] = 1; pts += 2 * mult; hits++;
          end else if (press[i] && row_pre[i]) begin
            m_code[i] = 2; pts += 1 * mult; hits++;
          end else if (press[i]) begin
            m_code[i] = 4; faults++;
          end else if (row_last[i] && m_cons[i] == 0) begin
            m_code[i] = 3; faults++;
          end
          m_cons[i] = (m_code[i] == 2) ? 1 : 0;
        end
      end
      if (m_pinc > 0 && m_pdec > 0) begin
        m_pinc--; m_pdec--; m_inc = 0; m_dec = 0;
      end else if (m_pinc > 0) begin
        m_pinc--; m_inc = 1; m_dec = 0;
      end else if (m_pdec > 0) begin
        m_pdec--; m_inc = 0; m_dec = 1;
      end else begin
        m_inc = 0; m_dec = 0;
      end
      m_pinc = min_i(63, m_pinc + pts);
      m_pdec = min_i(63, m_pdec + faults);
      if (faults > 0) m_combo = 0;
      else            m_combo = min_i(255, m_combo + hits);
      if (m_combo > m_max) m_max = m_combo;
    end
  end

  function automatic logic [11:0] exp_judge();
    logic [11:0] v = '0;
    for (int i = 0; i < 4; i++) v[3*i +: 3] = 3'(m_code[i]);
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_judge", 32'(judge), 32'(exp_judge()));
      check("cyc_combo", 32'(combo), 32'(m_combo));
      check("cyc_max_combo", 32'(max_combo), 32'(m_max));
      check("cyc_inc", 32'(inc), 32'(m_inc));
      check("cyc_dec", 32'(dec), 32'(m_dec));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] pre, input logic [3:0] last,
                       input logic [3:0] prs, input logic en);
    @(negedge clk);
    row_pre  = pre;
    row_last = last;
    press    = prs;
    enable   = en;
  endtask

  task automatic idle();
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
  endtask

  task automatic count_pulses(input int n, output int n_inc, output int n_dec);
    n_inc = 0;
    n_dec = 0;
    for (int k = 0; k < n; k++) begin
      idle();
      if (inc === 1'b1) n_inc++;
      if (dec === 1'b1) n_dec++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ni, nd, run_mode;
    logic [3:0] r_pre, r_last, r_press;

    reset = 1'b0; enable = 1'b0;
    row_pre = '0; row_last = '0; press = '0;
    repeat (2) @(negedge clk);
    check("reset_judge", 32'(judge), 32'h0);
    check("reset_combo", 32'(combo), 32'h0);
    check("reset_max", 32'(max_combo), 32'h0);
    check("reset_incdec", 32'({inc, dec}), 32'h0);
    #2 reset = 1'b1;
    check_en = 1'b1;
    idle();

    // Reset mid-run: build up combo and pending pulses, then clear them.
    repeat (7) drive(4'b0000, 4'b0001, 4'b0001, 1'b1);
    idle();
    check("midrun_combo_before", 32'(combo), 32'd7);
    #2 reset = 1'b0;
    #1;
    check("midrun_judge_zero", 32'(judge), 32'h0);
    check("midrun_combo_zero", 32'(combo), 32'h0);
    check("midrun_max_zero", 32'(max_combo), 32'h0);
    check("midrun_incdec_zero", 32'({inc, dec}), 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    count_pulses(10, ni, nd);
    check("midrun_no_inc_after", 32'(ni), 32'd0);
    check("midrun_no_dec_after", 32'(nd), 32'd0);

    // Perfect hit on lane 0.
    drive(4'b0000, 4'b0001, 4'b0001, 1'b1);
    idle();
    check("perfect_judge", 32'(judge), 32'h001);
    check("perfect_combo", 32'(combo), 32'd1);
    check("perfect_inc_t1", 32'(inc), 32'd0);
    idle();
    check("perfect_inc_t2", 32'(inc), 32'd1);
    idle();
    check("perfect_inc_t3", 32'(inc), 32'd1);
    idle();
    check("perfect_inc_t4", 32'(inc), 32'd0);

    // Early hit on lane 1, then the arrow reaches the bottom unpressed.
    drive(4'b0010, 4'b0000, 4'b0010, 1'b1);
    drive(4'b0000, 4'b0010, 4'b0000, 1'b1);
    check("early_judge_good", 32'(judge), 32'h010);
    check("early_inc_t1", 32'(inc), 32'd0);
    idle();
    check("early_judge_none", 32'(judge), 32'h000);
    check("early_inc_t2", 32'(inc), 32'd1);
    count_pulses(8, ni, nd);
    check("early_extra_inc", 32'(ni), 32'd0);
    check("early_dec", 32'(nd), 32'd0);
    check("early_combo", 32'(combo), 32'd2);

    // Miss breaks a combo of 5.
    repeat (3) drive(4'b0000, 4'b1000, 4'b1000, 1'b1);
    count_pulses(12, ni, nd);
    check("miss_combo_before", 32'(combo), 32'd5);
    drive(4'b0000, 4'b0100, 4'b0000, 1'b1);
    idle();
    check("miss_judge", 32'(judge), 32'h0C0);
    check("miss_combo", 32'(combo), 32'd0);
    check("miss_max", 32'(max_combo), 32'd5);
    count_pulses(8, ni, nd);
    check("miss_dec_pulses", 32'(nd), 32'd1);
    check("miss_inc_pulses", 32'(ni), 32'd0);

    // Bonus PERFECT with a STRAY in the same cycle.
    repeat (10) drive(4'b0000, 4'b0001, 4'b0001, 1'b1);
    count_pulses(40, ni, nd);
    check("bonus_combo_before", 32'(combo), 32'd10);
    drive(4'b0000, 4'b0001, 4'b0011, 1'b1);
    idle();
    check("bonus_judge", 32'(judge), 32'h021);
    check("bonus_combo", 32'(combo), 32'd0);
    check("bonus_inc_t1", 32'(inc), 32'd0);
    count_pulses(10, ni, nd);
    check("bonus_inc_pulses", 32'(ni), 32'd3);
    check("bonus_dec_pulses", 32'(nd), 32'd0);

    // Saturation of the pending-increment counter.
    repeat (3) drive(4'b0000, 4'b1111, 4'b1111, 1'b1);
    repeat (8) drive(4'b0000, 4'b1111, 4'b1111, 1'b1);
    idle();
    check("sat_combo", 32'(combo), 32'd44);
    check("sat_max", 32'(max_combo), 32'd44);
    count_pulses(70, ni, nd);
    check("sat_inc_pulses", 32'(ni), 32'd63);
    check("sat_dec_pulses", 32'(nd), 32'd0);

    // Enable low: nothing graded, combo holds.
    drive(4'b0000, 4'b1111, 4'b0101, 1'b0);
    idle();
    check("disable_judge", 32'(judge), 32'h000);
    check("disable_combo", 32'(combo), 32'd44);

    // Randomized run in bursts of skilled or sloppy play.
    run_mode = 0;
    for (int c = 0; c < 800; c++) begin
      if (c % 25 == 0) run_mode = $urandom_range(0, 2);
      r_pre  = 4'($urandom_range(0, 15));
      r_last = 4'($urandom_range(0, 15));
      case (run_mode)
        0:       r_press = r_last;
        1:       r_press = ($urandom_range(0, 3) == 0) ? r_pre : r_last;
        default: r_press = 4'($urandom_range(0, 15));
      endcase
      drive(r_pre, r_last, r_press, ($urandom_range(0, 9) != 0));
    end
    count_pulses(80, ni, nd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
